tpfu_sequencer: RTL and testbench

Programmable sequencer for the Temporally Programmed Functional Unit (TP-FU). It holds a writable instruction memory and tracks an input burst that is written into the FU register file. Once the burst ends it issues the stored program to the FU one instruction per cycle, then tags FU results and signals completion. It sits between the stream interface and the FU decode/regfile/`alu_core` datapath, replacing the fixed ROM and the valid-edge control logic.

---
 rtl/tpfu_pkg.sv | 35 +++
 rtl/tpfu_if.sv | 37 +++
 rtl/tpfu_imem.sv | 30 +++
 rtl/tpfu_sequencer.sv | 146 ++++++++++++++
 tb/tb_tpfu_sequencer.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/tpfu_pkg.sv
// tpfu_pkg: shared constants and types for the TP-FU sequencer slice.
//   INST_W / IMEM_AW / RF_AW  widths of instruction, imem address, regfile address
//   *_MSB / *_LSB             instruction field positions
//   OP_*                      FU opcodes
//   seq_state_t               sequencer FSM state encoding
package tpfu_pkg;

    localparam int INST_W  = 24;
    localparam int IMEM_AW = 4;
    localparam int RF_AW   = 6;

    localparam int OPC_MSB  = 23;
    localparam int OPC_LSB  = 18;
    localparam int DST_MSB  = 17;
    localparam int DST_LSB  = 12;
    localparam int SRC1_MSB = 11;
    localparam int SRC1_LSB = 6;
    localparam int SRC2_MSB = 5;
    localparam int SRC2_LSB = 0;

    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_MUL  = 6'h03;
    localparam logic [5:0] OP_ADDI = 6'h05;
    localparam logic [5:0] OP_SUBI = 6'h06;
    localparam logic [5:0] OP_MULI = 6'h07;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DRAIN = 2'd3
    } seq_state_t;

endpackage

// File: rtl/tpfu_if.sv
// tpfu_if: sequencer-facing bundle (program port, input stream, regfile write,
// FU issue and result tagging).
//   master  the sequencer itself
//   slave   the environment around it (stream source, FU datapath, host)
interface tpfu_if;
    import tpfu_pkg::*;

    logic               prog_we;
    logic [IMEM_AW-1:0] prog_addr;
    logic [INST_W-1:0]  prog_data;
    logic [IMEM_AW:0]   prog_len;
    logic               prog_err;
    logic               din_valid;
    logic               din_ready;
    logic               rf_we;
    logic [RF_AW-1:0]   rf_waddr;
    logic [RF_AW:0]     n_words;
    logic [INST_W-1:0]  inst;
    logic               inst_v;
    logic               res_v;
    logic [IMEM_AW-1:0] res_idx;
    logic               busy;
    logic               done;

    modport master (
        input  prog_we, prog_addr, prog_data, prog_len, din_valid,
        output prog_err, din_ready, rf_we, rf_waddr, n_words,
               inst, inst_v, res_v, res_idx, busy, done
    );

    modport slave (
        output prog_we, prog_addr, prog_data, prog_len, din_valid,
        input  prog_err, din_ready, rf_we, rf_waddr, n_words,
               inst, inst_v, res_v, res_idx, busy, done
    );

endinterface

// File: rtl/tpfu_imem.sv
// tpfu_imem: 2^IMEM_AW x INST_W instruction memory, one write port, one
// synchronous read port. Contents have no reset so a program survives rst;
// only the read register is cleared.
//   we/waddr/wdata  write port
//   re/raddr        read request, data appears on rdata the next cycle
module tpfu_imem
    import tpfu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [IMEM_AW-1:0] waddr,
    input  logic [INST_W-1:0]  wdata,
    input  logic               re,
    input  logic [IMEM_AW-1:0] raddr,
    output logic [INST_W-1:0]  rdata
);

    logic [INST_W-1:0] mem [2**IMEM_AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/tpfu_sequencer.sv
// tpfu_sequencer: captures an input burst into the FU regfile, then issues the
// stored program one instruction per cycle and tags FU results.
//   clk, rst  clock, synchronous active-high reset
//   bus       tpfu_if.master (program port, stream, regfile, issue, results)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for a burst; program writes accepted
// ST_LOAD  | burst in progress, words written at the running counter
// ST_ISSUE | pc walks 0..len-1 through the synchronous imem read
// ST_DRAIN | waiting for the last FU result (done), then back to IDLE
module tpfu_sequencer
    import tpfu_pkg::*;
#(
    parameter int FU_LATENCY = 4    // must be >= 2
) (
    input logic    clk,
    input logic    rst,
    tpfu_if.master bus
);

    localparam logic [RF_AW:0]   CNT_FULL = {1'b1, {RF_AW{1'b0}}};
    localparam logic [IMEM_AW:0] LEN_MAX  = {1'b1, {IMEM_AW{1'b0}}};

    seq_state_t         state_q, state_d;
    logic [RF_AW:0]     cnt_q, cnt_d;
    logic [IMEM_AW-1:0] pc_q;
    logic [IMEM_AW:0]   len_q, len_clamped;
    logic [RF_AW:0]     n_words_q;
    logic               din_ready_q, prog_err_q, busy_q, done_q;
    logic               iss_v_q, iss_last_q;
    logic [IMEM_AW-1:0] iss_idx_q;
    logic               wr_fire, pc_last, load_exit;
    logic [INST_W-1:0]  imem_rdata;

    // result delay line: stage FU_LATENCY-1 drives res_v/res_idx
    logic               p_v   [FU_LATENCY];
    logic [IMEM_AW-1:0] p_idx [FU_LATENCY];
    logic               p_last[FU_LATENCY-1];

    assign wr_fire     = bus.din_valid & din_ready_q;
    assign pc_last     = ({1'b0, pc_q} == (len_q - (IMEM_AW+1)'(1)));
    assign load_exit   = (state_q == ST_LOAD) && (state_d == ST_ISSUE);
    assign len_clamped = (bus.prog_len > LEN_MAX) ? LEN_MAX : bus.prog_len;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (wr_fire) state_d = ST_LOAD;
            ST_LOAD:  if (cnt_q == CNT_FULL || !bus.din_valid) state_d = ST_ISSUE;
            ST_ISSUE: if (len_q == '0 || pc_last) state_d = ST_DRAIN;
            ST_DRAIN: if (done_q) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // counter returns to 0 on leaving LOAD so IDLE always writes address 0
    always_comb begin
        cnt_d = cnt_q;
        if (load_exit)    cnt_d = '0;
        else if (wr_fire) cnt_d = cnt_q + (RF_AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pc_q        <= '0;
            len_q       <= '0;
            n_words_q   <= '0;
            din_ready_q <= 1'b0;
            prog_err_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            iss_v_q     <= 1'b0;
            iss_idx_q   <= '0;
            iss_last_q  <= 1'b0;
            for (int k = 0; k < FU_LATENCY; k++) begin
                p_v[k]   <= 1'b0;
                p_idx[k] <= '0;
            end
            for (int k = 0; k < FU_LATENCY-1; k++) p_last[k] <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= (state_d != ST_IDLE);
            // drop ready the cycle after the 64th write, before LOAD exits
            din_ready_q <= (state_d == ST_IDLE) ||
                           (state_d == ST_LOAD && cnt_d != CNT_FULL);
            prog_err_q  <= bus.prog_we && (state_q != ST_IDLE);

            if (load_exit) begin
                n_words_q <= cnt_q;
                len_q     <= len_clamped;
            end

            if (state_q == ST_ISSUE) begin
                pc_q <= (state_d == ST_DRAIN) ? '0 : pc_q + (IMEM_AW)'(1);
            end

            iss_v_q <= (state_q == ST_ISSUE) && (len_q != '0);
            if (state_q == ST_ISSUE) begin
                iss_idx_q  <= pc_q;
                iss_last_q <= pc_last;
            end

            p_v[0]    <= iss_v_q;
            p_idx[0]  <= iss_idx_q;
            p_last[0] <= iss_v_q & iss_last_q;
            for (int k = 1; k < FU_LATENCY; k++) begin
                p_v[k]   <= p_v[k-1];
                p_idx[k] <= p_idx[k-1];
            end
            for (int k = 1; k < FU_LATENCY-1; k++) p_last[k] <= p_last[k-1];

            // registered so it lands with the last res_v; empty program
            // pulses it straight out of ISSUE
            done_q <= p_last[FU_LATENCY-2] |
                      ((state_q == ST_ISSUE) && (len_q == '0));
        end
    end

    tpfu_imem u_imem (
        .clk   (clk),
        .rst   (rst),
        .we    (bus.prog_we && (state_q == ST_IDLE)),
        .waddr (bus.prog_addr),
        .wdata (bus.prog_data),
        .re    ((state_q == ST_ISSUE) && (len_q != '0)),
        .raddr (pc_q),
        .rdata (imem_rdata)
    );

    assign bus.din_ready = din_ready_q;
    assign bus.rf_we     = wr_fire;
    assign bus.rf_waddr  = cnt_q[RF_AW-1:0];
    assign bus.n_words   = n_words_q;
    assign bus.prog_err  = prog_err_q;
    assign bus.inst      = imem_rdata;
    assign bus.inst_v    = iss_v_q;
    assign bus.res_v     = p_v[FU_LATENCY-1];
    assign bus.res_idx   = p_idx[FU_LATENCY-1];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_tpfu_sequencer.sv
// tb_tpfu_sequencer: directed bench for tpfu_sequencer. Expected timing is
// derived from the burst length and program length relative to cycle B.
module tb_tpfu_sequencer;
    import tpfu_pkg::*;

    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst;

    tpfu_if bus();

    tpfu_sequencer #(.FU_LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    logic [INST_W-1:0] img [16];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bus.din_ready, bus.prog_err, bus.rf_we, bus.rf_waddr, bus.n_words,
                    bus.inst, bus.inst_v, bus.res_v, bus.res_idx, bus.busy, bus.done});
    endfunction

    task automatic prog_write(input int a, input logic [INST_W-1:0] d);
        bus.prog_we   = 1'b1;
        bus.prog_addr = a[IMEM_AW-1:0];
        bus.prog_data = d;
        tick();
        bus.prog_we = 1'b0;
        img[a] = d;
        #1;
        chk("perr_idle", 64'(bus.prog_err), 64'(0));
    endtask

    // Burst of nb words, program length plen (as driven), optional dropped
    // program write at cycle err_c. Cycle 0 is the first burst cycle.
    task automatic run(input string tag, input int nb, input int plen, input int err_c);
        int b, eff, done_c;
        bit in_iss, in_res, wr;
        eff    = (plen > 16) ? 16 : plen;
        b      = (nb > 64) ? 64 : nb;
        done_c = (eff == 0) ? b + 2 : b + 1 + eff + LAT;
        bus.prog_len = 5'(plen);
        for (int c = 0; c <= done_c; c++) begin
            bus.din_valid = (c < nb);
            bus.prog_we   = (c == err_c);
            if (c == err_c) begin
                bus.prog_addr = '0;
                bus.prog_data = 24'hABCDEF;
            end
            #1;
            wr     = (c < nb) && (c < 64);
            in_iss = (c >= b + 2) && (c <= b + 1 + eff);
            in_res = (c >= b + 2 + LAT) && (c <= b + 1 + eff + LAT);
            chk($sformatf("%s.rf_we@%0d", tag, c), 64'(bus.rf_we), 64'(wr));
            if (wr) chk($sformatf("%s.rf_waddr@%0d", tag, c), 64'(bus.rf_waddr), 64'(c));
            chk($sformatf("%s.din_ready@%0d", tag, c), 64'(bus.din_ready),
                64'((c <= b) && (c < 64)));
            chk($sformatf("%s.busy@%0d", tag, c), 64'(bus.busy), 64'(c >= 1));
            chk($sformatf("%s.inst_v@%0d", tag, c), 64'(bus.inst_v), 64'(in_iss));
            if (in_iss) chk($sformatf("%s.inst@%0d", tag, c), 64'(bus.inst), 64'(img[c-b-2]));
            chk($sformatf("%s.res_v@%0d", tag, c), 64'(bus.res_v), 64'(in_res));
            if (in_res) chk($sformatf("%s.res_idx@%0d", tag, c), 64'(bus.res_idx),
                            64'(c - b - 2 - LAT));
            chk($sformatf("%s.done@%0d", tag, c), 64'(bus.done), 64'(c == done_c));
            chk($sformatf("%s.prog_err@%0d", tag, c), 64'(bus.prog_err),
                64'((err_c >= 0) && (c == err_c + 1)));
            if (c == b + 1) chk($sformatf("%s.n_words", tag), 64'(bus.n_words), 64'(b));
            tick();
        end
        bus.din_valid = 1'b0;
        bus.prog_we   = 1'b0;
        #1;
        chk($sformatf("%s.idle_busy", tag), 64'(bus.busy), 64'(0));
        chk($sformatf("%s.idle_ready", tag), 64'(bus.din_ready), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        bus.prog_len  = '0;
        bus.din_valid = 1'b0;

        // power-on reset
        repeat (3) tick();
        chk("por_outs_zero", all_outs(), 64'(0));
        rst = 1'b0;
        tick();
        chk("por_ready", 64'(bus.din_ready), 64'(1));

        prog_write(0, 24'h1D0001);
        prog_write(1, 24'h150045);
        prog_write(2, 24'h180094);
        prog_write(3, 24'h1800D4);

        // basic run followed immediately by a back-to-back run
        run("basic", 4, 4, -1);
        run("b2b", 4, 4, -1);

        run("empty", 2, 0, -1);

        // write dropped during ISSUE (B=3, ISSUE spans cycles 4..7), then rerun
        run("drop", 3, 4, 5);
        run("after_drop", 3, 4, -1);

        run("full", 70, 4, -1);

        for (int a = 4; a < 16; a++) prog_write(a, 24'(32'h0C0000 + a * 32'h1041));
        run("clamp", 5, 31, -1);

        // reset in the middle of ISSUE
        bus.prog_len = 5'd4;
        for (int c = 0; c < 3; c++) begin
            bus.din_valid = 1'b1;
            tick();
        end
        bus.din_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus.inst_v) break;
            tick();
        end
        chk("mid_inst_v_seen", 64'(bus.inst_v), 64'(1));
        rst = 1'b1;
        repeat (3) tick();
        chk("mid_rst_outs_zero", all_outs(), 64'(0));
        rst = 1'b0;
        tick();
        chk("mid_rst_ready", 64'(bus.din_ready), 64'(1));
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("mid_quiet@%0d", k), 64'({bus.res_v, bus.done, bus.inst_v}), 64'(0));
            tick();
        end
        run("rerun", 4, 4, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
